// File: rtl/regfile_ctrl_pkg.sv
`ifndef XLEN
`define XLEN 32
`endif
// Shared types and defaults for the register-file write controller.
// No logic of its own; sizes the writeback request from the default register count.
// Backpressure is handled by the modules that use these types.
package regfile_ctrl_pkg;
    localparam int DEF_REGISTER_COUNT = 32;
    localparam int DEF_MAX_PENDING    = 4;
    localparam int DEF_STARVE_LIMIT   = 4;
    localparam int PKG_XLEN           = `XLEN;
    localparam int PKG_AW             = $clog2(DEF_REGISTER_COUNT);

    // One writeback offer towards the register-file write port.
    typedef struct packed {
        logic                valid;
        logic [PKG_AW-1:0]   adr;
        logic [PKG_XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/reg_scoreboard.sv
`ifndef XLEN
`define XLEN 32
`endif
// Per-register pending bits for long-latency destinations plus a population count.
// Lookups are combinational; set/clear take effect on the next rising edge.
// Exposes full so the issue stage stops new long ops once MAX_PENDING are in flight.
module reg_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int REGISTER_COUNT = DEF_REGISTER_COUNT,
    parameter int MAX_PENDING    = DEF_MAX_PENDING,
    localparam int AW            = $clog2(REGISTER_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_adr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_adr,
    input  logic [AW-1:0] rs1_adr,
    input  logic [AW-1:0] rs2_adr,
    input  logic [AW-1:0] rd_adr,
    input  logic          long_lat,
    output logic          hazard,
    output logic          full
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [REGISTER_COUNT-1:0] pending;
    logic [CW-1:0]             pend_count;
    logic                      do_set;
    logic                      do_clr;
    logic                      inc;

    // Qualify strobes: x0 is never tracked, a clear only counts if the bit is
    // really set, and a same-register set overrides the clear.
    always_comb begin
        do_set = set_en && (set_adr != '0);
        do_clr = clr_en && (clr_adr != '0) && pending[clr_adr]
                 && !(do_set && (set_adr == clr_adr));
        inc    = do_set && !pending[set_adr];
    end

    // Pending bits and their count; set is applied after clear so set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            if (do_clr) pending[clr_adr] <= 1'b0;
            if (do_set) pending[set_adr] <= 1'b1;
            case ({inc, do_clr})
                2'b10:   pend_count <= pend_count + 1'b1;
                2'b01:   pend_count <= pend_count - 1'b1;
                default: pend_count <= pend_count;
            endcase
        end
    end

    // RAW on nonzero sources, WAW on the destination; pending[0] is never set.
    always_comb begin
        hazard = ((rs1_adr != '0) && pending[rs1_adr])
              || ((rs2_adr != '0) && pending[rs2_adr])
              || pending[rd_adr];
        full   = long_lat && (pend_count == CW'(MAX_PENDING));
    end
endmodule

// File: rtl/regfile_write_controller.sv
`ifndef XLEN
`define XLEN 32
`endif
// Arbitrates the single register-file write port between ALU and long-latency results.
// Zero-cycle write path; scoreboard and starvation state update on the rising edge.
// ALU never stalls; long unit is refused while ALU writes, and starvation stalls issue.
module regfile_write_controller
    import regfile_ctrl_pkg::*;
#(
    parameter int REGISTER_COUNT = DEF_REGISTER_COUNT,
    parameter int MAX_PENDING    = DEF_MAX_PENDING,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    localparam int AW            = $clog2(REGISTER_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IssueValid,
    input  logic [AW-1:0]     IssueRs1Adr,
    input  logic [AW-1:0]     IssueRs2Adr,
    input  logic [AW-1:0]     IssueRdAdr,
    input  logic              IssueLongLat,
    output logic              IssueStall,
    input  logic              AluWbValid,
    input  logic [AW-1:0]     AluWbAdr,
    input  logic [`XLEN-1:0]  AluWbData,
    input  logic              LongWbValid,
    input  logic [AW-1:0]     LongWbAdr,
    input  logic [`XLEN-1:0]  LongWbData,
    output logic              LongWbReady,
    output logic              WriteEn,
    output logic [AW-1:0]     rd1Adr,
    output logic [`XLEN-1:0]  Rd1
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t       alu_req;
    wb_req_t       long_req;
    wb_req_t       sel_req;
    logic          alu_sel;
    logic          long_acc;
    logic          issue_acc;
    logic          hazard;
    logic          full;
    logic          starve;
    logic [SW-1:0] starve_cnt;

    // Write-port mux: a real ALU write always wins; x0 writes are swallowed.
    always_comb begin
        alu_req       = '{valid: AluWbValid,  adr: AluWbAdr,  data: AluWbData};
        long_req      = '{valid: LongWbValid, adr: LongWbAdr, data: LongWbData};
        alu_sel       = alu_req.valid && (alu_req.adr != '0);
        LongWbReady   = !alu_sel;
        long_acc      = long_req.valid && LongWbReady;
        sel_req       = alu_sel ? alu_req : long_req;
        sel_req.valid = alu_sel || (long_acc && (long_req.adr != '0));
        WriteEn       = sel_req.valid;
        rd1Adr        = sel_req.adr;
        Rd1           = sel_req.data;
    end

    // Issue stall; pending state is read before this cycle's writeback clears it.
    always_comb begin
        starve     = (starve_cnt == SW'(STARVE_LIMIT));
        IssueStall = IssueValid && (hazard || full || starve);
        issue_acc  = IssueValid && !IssueStall;
    end

    // Count consecutive refused long offers; any accept or idle cycle restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!LongWbValid || long_acc) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    reg_scoreboard #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .MAX_PENDING    (MAX_PENDING)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_acc && IssueLongLat),
        .set_adr  (IssueRdAdr),
        .clr_en   (long_acc),
        .clr_adr  (LongWbAdr),
        .rs1_adr  (IssueRs1Adr),
        .rs2_adr  (IssueRs2Adr),
        .rd_adr   (IssueRdAdr),
        .long_lat (IssueLongLat),
        .hazard   (hazard),
        .full     (full)
    );
endmodule
